icache_nway: RTL
================

Name: icache_nway

Overview:
N-way set-associative instruction cache with line refill, the parametrised successor of the 2-set lookup-only cache.
- Sits between the fetch stage and the instruction memory port.
- Serves hits combinationally.
- On a miss, fetches a full line from memory one word per handshake, then replays the lookup.
- Adds replacement, explicit flush and a configurable invalidate sweep.

Parameters:
WAYS, 2, number of ways (power of 2, 1..8)
SETS, 128, sets per way (power of 2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=1)
ADDR_WIDTH, 32, byte address width

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  synchronous reset, active-low
i_addr  in  ADDR_WIDTH  fetch byte address (bits [1:0] ignored)
i_rd  in  1  fetch request, held until o_valid
o_inst  out  32  instruction, meaningful only when o_valid=1
o_valid  out  1  hit: o_inst holds the word at i_addr this cycle
o_busy  out  1  cache cannot accept a request (INIT, REFILL, FILL_DONE)
i_flush  in  1  invalidate all lines (single-cycle pulse)
o_mem_addr  out  ADDR_WIDTH  refill word address, word aligned
o_mem_rd  out  1  refill read request
i_mem_data  in  32  refill data
i_mem_ack  in  1  data valid; completes the current o_mem_rd

Behaviour:
- Interface: reset i_reset, synchronous, active-low; clock i_clock.
- Address split, LSB first:
  - byte [1:0]
  - word log2(LINE_WORDS)
  - index log2(SETS)
  - tag = remaining bits.
- Per way: valid bit, tag and LINE_WORDS data words per set. Per set: round-robin victim pointer of log2(WAYS) bits.
- Reset (i_reset=0 at an edge): state=INIT, sweep counter=0, flush_pending=0, all victim pointers=0.
- Outputs during reset: o_valid=0, o_busy=1, o_mem_rd=0, o_inst=0, o_mem_addr=0.
- States and transitions:
  - INIT: clears the valid bits of all ways at set=counter, one set per cycle, counter+1. After set SETS-1 goes to IDLE. Takes exactly SETS cycles; o_busy=1.
  - IDLE:
    - hit = i_rd & any way with valid & tag match at the index.
    - Hit: o_valid=1, o_inst=data[way][index][word] in the same cycle (0-cycle latency).
    - Multiple matching ways is illegal; lowest-index way wins (assertion in bench).
    - i_rd with no hit: latch line base address (word field=0) and victim way; go to REFILL; o_valid=0.
    - Victim way = lowest-index invalid way, otherwise the set's round-robin pointer.
    - i_flush=1 in IDLE: go to INIT. Flush takes priority over a simultaneous miss; a simultaneous hit still returns o_valid=1 that cycle.
  - REFILL:
    - o_mem_rd=1, o_mem_addr = line base + 4*k, k=0..LINE_WORDS-1, held stable until i_mem_ack.
    - On ack: write i_mem_data into victim data[k], k+1.
    - On ack with k=LINE_WORDS-1: write tag, set valid, advance the set's pointer (mod WAYS), go to FILL_DONE.
    - Valid stays 0 during the fill.
    - i_flush during REFILL sets flush_pending; the refill is not aborted.
  - FILL_DONE: one cycle, o_busy=1. Goes to INIT if flush_pending (then clears it), else to IDLE, where the replayed lookup hits.
- o_busy=0 only in IDLE.
- i_rd deasserted or i_addr changed during REFILL: refill still completes. The requester must hold i_addr until o_valid.
- Reset mid-REFILL or mid-INIT: o_mem_rd drops in the next cycle, the partial line is never marked valid, and INIT restarts from set 0.
- WAYS=1: the victim pointer has zero width and the victim is always way 0.
- Counters: sweep counter log2(SETS)+1 bits; word counter log2(LINE_WORDS)+1 bits. Wrap is not permitted.

Decomposition:
- Shared package (icache_pkg):
  - state enum {INIT, IDLE, REFILL, FILL_DONE}
  - address-field width functions (tag/index/word width from parameters)
  - inst_t = logic [31:0]
  - line-address struct type.
- Sub-module icache_way: one way's valid/tag/data arrays.
  - Inputs: index, word, write-enable, write-tag, clear-valid.
  - Outputs: hit and read word.
  - Instantiated WAYS times via generate.
- The top holds the FSM, the victim pointers and the hit mux.

Test Plan:
1. Reset low 2 cycles, then high, WAYS=2, SETS=128 -> o_busy=1 for exactly 128 cycles after release, then 0; o_mem_rd=0 throughout.
2. i_rd, i_addr=0x100, LINE_WORDS=4, memory acks after 2 cycles with data 0xA0..0xA3 -> o_mem_addr 0x100, 0x104, 0x108, 0x10C in order. Then 0x10C returns 0xA3, and 0x104 hits with o_valid=1, o_inst=0xA1 in the request cycle.
3. Misses to 0x0100, 0x2100, 0x4100 (same index, SETS=128, LINE_WORDS=4) -> the first two fill ways 0 and 1. The third evicts way 0 (pointer), so 0x0100 misses again and 0x2100 still hits.
4. After test 2, pulse i_flush in IDLE -> 128 busy cycles, then 0x100 misses. Flush pulsed mid-REFILL -> the refill finishes all 4 acks, then 128 INIT cycles.
5. Reset asserted after the 2nd ack of a refill -> o_mem_rd=0 the next cycle; after INIT, the same address misses and refetches from word 0.
6. Hit in IDLE with simultaneous i_flush -> o_valid=1 with correct data that cycle, then INIT.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the N-way instruction cache.
// Field widths are derived from the cache geometry parameters.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_REFILL,
        ST_FILL_DONE
    } state_t;

    typedef logic [31:0] inst_t;

    localparam int unsigned ADDR_MAX    = 64;
    localparam int unsigned WAY_IDX_MAX = 3;

    // Line being refilled: word-aligned base address plus the victim way.
    typedef struct packed {
        logic [ADDR_MAX-1:0]    base;
        logic [WAY_IDX_MAX-1:0] way;
    } line_addr_t;

    function automatic int unsigned word_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned index_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned way_bits(input int unsigned ways);
        return $clog2(ways);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_width,
                                             input int unsigned sets,
                                             input int unsigned line_words);
        return addr_width - 2 - $clog2(sets) - $clog2(line_words);
    endfunction

    // Zero-width fields still need a 1-bit carrier vector.
    function automatic int unsigned min1(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and line data, with a
// combinational lookup at i_index.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_W      = 21,
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned WRD_W      = 2
) (
    input  logic             i_clock,
    input  logic [IDX_W-1:0] i_index,
    input  logic [WRD_W-1:0] i_word,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_data_we,
    input  logic [WRD_W-1:0] i_wr_word,
    input  inst_t            i_wr_data,
    input  logic             i_tag_we,
    input  logic             i_clr_valid,
    output logic             o_hit,
    output logic             o_valid,
    output inst_t            o_data
);

    logic             valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS];
    inst_t            data_q  [SETS][LINE_WORDS];

    always_ff @(posedge i_clock) begin
        if (i_clr_valid) begin
            valid_q[i_index] <= 1'b0;
        end else if (i_tag_we) begin
            valid_q[i_index] <= 1'b1;
        end
        if (i_tag_we) begin
            tag_q[i_index] <= i_tag;
        end
        if (i_data_we) begin
            data_q[i_index][i_wr_word] <= i_wr_data;
        end
    end

    always_comb begin
        o_valid = valid_q[i_index];
        o_hit   = valid_q[i_index] && (tag_q[i_index] == i_tag);
        o_data  = data_q[i_index][i_word];
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: combinational hits, word-serial
// line refill with round-robin replacement, flush and reset-time invalidate sweep.
module icache_nway
    import icache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 128,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd,
    output inst_t                 o_inst,
    output logic                  o_valid,
    output logic                  o_busy,
    input  logic                  i_flush,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd,
    input  inst_t                 i_mem_data,
    input  logic                  i_mem_ack
);

    localparam int unsigned WB    = word_bits(LINE_WORDS);
    localparam int unsigned IB    = index_bits(SETS);
    localparam int unsigned TB    = tag_bits(ADDR_WIDTH, SETS, LINE_WORDS);
    localparam int unsigned WW    = min1(WB);
    localparam int unsigned WAY_W = min1(way_bits(WAYS));
    localparam int unsigned OFF   = 2 + WB;
    localparam int unsigned CW    = IB + 1;
    localparam int unsigned KW    = WB + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic              fp_q, fp_d;
    line_addr_t        line_q, line_d;
    logic [WAY_W-1:0]  rr_q [SETS];

    logic [ADDR_WIDTH-1:0] line_base, look_addr;
    logic [IB-1:0]         set_idx;
    logic [TB-1:0]         set_tag;
    logic [WW-1:0]         rd_word;
    logic [WAY_W-1:0]      fill_way, hit_way, victim;
    logic                  hit, rr_adv;
    logic [WAYS-1:0]       hit_vec, valid_vec, clr_vec, data_we_vec, tag_we_vec;
    inst_t                 rdata [WAYS];
    logic                  unused_bits;

    // IDLE looks up the fetch address; REFILL/FILL_DONE address the line being filled.
    always_comb begin
        line_base = line_q.base[ADDR_WIDTH-1:0];
        look_addr = (state_q == ST_IDLE) ? i_addr : line_base;
        set_idx   = (state_q == ST_INIT) ? cnt_q[IB-1:0] : look_addr[OFF +: IB];
        set_tag   = look_addr[ADDR_WIDTH-1 -: TB];
        rd_word   = (LINE_WORDS > 1) ? look_addr[2 +: WW] : '0;
        fill_way  = line_q.way[WAY_W-1:0];
    end

    assign unused_bits = ^{line_q, look_addr};

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS      (SETS),
            .LINE_WORDS(LINE_WORDS),
            .TAG_W     (TB),
            .IDX_W     (IB),
            .WRD_W     (WW)
        ) u_way (
            .i_clock    (i_clock),
            .i_index    (set_idx),
            .i_word     (rd_word),
            .i_tag      (set_tag),
            .i_data_we  (data_we_vec[w]),
            .i_wr_word  (k_q[WW-1:0]),
            .i_wr_data  (i_mem_data),
            .i_tag_we   (tag_we_vec[w]),
            .i_clr_valid(clr_vec[w]),
            .o_hit      (hit_vec[w]),
            .o_valid    (valid_vec[w]),
            .o_data     (rdata[w])
        );
    end

    // Descending scans so the lowest-index way is the last (winning) assignment.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = rr_q[set_idx];
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (hit_vec[w-1]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w - 1);
            end
            if (!valid_vec[w-1]) begin
                victim = WAY_W'(w - 1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        fp_d        = fp_q;
        line_d      = line_q;
        clr_vec     = '0;
        data_we_vec = '0;
        tag_we_vec  = '0;
        rr_adv      = 1'b0;
        o_valid     = 1'b0;
        o_busy      = 1'b1;
        o_mem_rd    = 1'b0;
        o_inst      = '0;
        o_mem_addr  = '0;
        case (state_q)
            ST_INIT: begin
                clr_vec = '1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_rd && hit) begin
                    o_valid = 1'b1;
                    o_inst  = rdata[hit_way];
                end
                if (i_flush) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (i_rd && !hit) begin
                    state_d     = ST_REFILL;
                    k_d         = '0;
                    line_d.base = '0;
                    line_d.base[ADDR_WIDTH-1:0] = {i_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                    line_d.way  = WAY_IDX_MAX'(victim);
                    clr_vec[victim] = 1'b1;
                end
            end
            ST_REFILL: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = line_base | (ADDR_WIDTH'(k_q) << 2);
                if (i_flush) begin
                    fp_d = 1'b1;
                end
                if (i_mem_ack) begin
                    data_we_vec[fill_way] = 1'b1;
                    k_d = k_q + 1'b1;
                    if (k_q == KW'(LINE_WORDS - 1)) begin
                        tag_we_vec[fill_way] = 1'b1;
                        rr_adv  = 1'b1;
                        state_d = ST_FILL_DONE;
                    end
                end
            end
            ST_FILL_DONE: begin
                if (fp_q || i_flush) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    fp_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // Held reset quiets the memory port and blocks any write of a partial line.
        if (!i_reset) begin
            o_valid     = 1'b0;
            o_busy      = 1'b1;
            o_mem_rd    = 1'b0;
            o_inst      = '0;
            o_mem_addr  = '0;
            clr_vec     = '0;
            data_we_vec = '0;
            tag_we_vec  = '0;
            rr_adv      = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            k_q     <= '0;
            fp_q    <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            fp_q    <= fp_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (rr_adv && (WAYS > 1)) begin
            rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
        end
    end

endmodule
